mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, address width; DATA_W, default 16, data width; RAM_AW, default 12, per-region word address width.
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- mX_req (X=0,1)  in  1  level request, held until mX_ready
- mX_we  in  1  1=write, 0=read
- mX_addr  in  ADDR_W  word address
- mX_wdata  in  DATA_W  write data
- mX_rdata  out  DATA_W  read data, valid with mX_ready
- mX_ready  out  1  one-cycle completion pulse
- mX_err  out  1  one-cycle pulse with mX_ready on unmapped access
- ram_ce, ram_oce, ram_we  out  1 each  RAM strobes
- vram_ce, vram_oce, vram_we  out  1 each  VRAM strobes
- mem_addr  out  RAM_AW  shared low address to both memories
- mem_wdata  out  DATA_W  shared write data
- ram_dout, vram_dout  in  DATA_W  synchronous-read memory outputs, valid the cycle after a read strobe

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; no other states.
REQ-004 IDLE: if any mX_req is high, grant one master, latch its we/addr/wdata, go to ACCESS; else stay.
REQ-005 Decode on addr[ADDR_W-1:ADDR_W-4]: 4'h0 RAM, 4'h1 VRAM, any other value unmapped.
REQ-006 ACCESS: exactly one cycle; assert the decoded region's ce, plus oce (read) or we (write); no strobe for unmapped.
REQ-007 RESP: exactly one cycle; pulse granted mX_ready; on a read, drive mX_rdata from the decoded region's dout; unmapped reads return 0 and pulse mX_err.
REQ-008 Latency: request seen in IDLE at cycle N gives ready at cycle N+2; back-to-back grants are 3 cycles apart.
REQ-009 The non-granted master SHALL see ready=0 and err=0; mX_rdata SHALL hold its last value between responses.
REQ-010 A request withdrawn mid-transaction SHALL still complete; the access is not cancelled.
REQ-011 Strobes SHALL be low in IDLE and RESP; never more than one region strobed per cycle.
REQ-012 Writes to unmapped space SHALL have no side effect other than ready+err.

Reset
REQ-013 While reset is low: FSM=IDLE, all strobes 0, ready/err 0, rdata 0, mem_addr/mem_wdata 0, priority pointer to m0.
REQ-014 Reset asserted mid-transaction SHALL abort it immediately; no ready is issued for it afterwards.

Configuration
REQ-015 MEM_ARB_RR_EN defined: round-robin arbitration; the pointer moves to the other master after each grant; simultaneous requests alternate.
REQ-016 MEM_ARB_RR_EN undefined: fixed priority, m0 always wins simultaneous requests; no pointer register.

Structure
REQ-017 Package mem_arb_pkg SHALL hold the FSM state enum, region codes (REG_RAM, REG_VRAM, REG_NONE) and region nibble constants 4'h0/4'h1.
REQ-018 Sub-module mem_region_decode SHALL map the address to a region code combinationally; the arbiter instantiates it once on the latched address.

Verification
REQ-019 m0 write 16'h0005 <- 16'hBEEF, then read 16'h0005 -> ram_we for one cycle, then m0_ready with m0_rdata=16'hBEEF two cycles after each request.
REQ-020 m1 read 16'h1010 -> vram_ce+vram_oce for one cycle, ram strobes 0, m1_rdata=vram_dout.
REQ-021 m0 read 16'h8000 -> no strobes, m0_ready and m0_err pulse together, m0_rdata=0.
REQ-022 Both masters request continuously with RR_EN -> grants m0,m1,m0,m1 three cycles apart; without RR_EN -> m0 only, m1 starved.
REQ-023 Reset low during ACCESS -> strobes drop at once, no ready pulse, IDLE after release.
REQ-024 m1_req dropped during ACCESS -> m1_ready still pulses in RESP.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory bus arbiter: FSM states, region codes
// and the address-nibble constants that select each region.
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_VRAM, REG_NONE} region_t;

  localparam logic [3:0] NIB_RAM  = 4'h0;
  localparam logic [3:0] NIB_VRAM = 4'h1;
endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decode from the top address nibble.
module mem_region_decode
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output region_t           region
);
  // Only the top nibble selects a region; the low bits belong to the memory.
  logic unused_low;
  assign unused_low = ^addr[ADDR_W-5:0];

  always_comb begin
    region = REG_NONE;
    case (addr[ADDR_W-1 -: 4])
      NIB_RAM:  region = REG_RAM;
      NIB_VRAM: region = REG_VRAM;
      default:  region = REG_NONE;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of RAM and VRAM: IDLE -> ACCESS -> RESP per transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (m0 wins).
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RAM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_we,
  output logic              vram_ce,
  output logic              vram_oce,
  output logic              vram_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] vram_dout
);
  logic [1:0]             req;
  logic [1:0]             we_in;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][DATA_W-1:0] wdata_in;

  assign req      = {m1_req, m0_req};
  assign we_in    = {m1_we, m0_we};
  assign addr_in  = {m1_addr, m0_addr};
  assign wdata_in = {m1_wdata, m0_wdata};

  state_t                 state;
  logic                   gnt;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic                   nxt_gnt;
  region_t                region;
  logic [DATA_W-1:0]      rd_val;

`ifdef MEM_ARB_RR_EN
  logic ptr;
  // Pointer names the master that wins the next tie; it flips past every grant.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                       ptr <= 1'b0;
    else if (state == S_IDLE && |req) ptr <= ~nxt_gnt;
  assign nxt_gnt = (&req) ? ptr : req[1];
`else
  assign nxt_gnt = ~req[0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      gnt     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (|req) begin
            gnt     <= nxt_gnt;
            we_q    <= we_in[nxt_gnt];
            addr_q  <= addr_in[nxt_gnt];
            wdata_q <= wdata_in[nxt_gnt];
            state   <= S_ACCESS;
          end
        S_ACCESS: state <= S_RESP;
        S_RESP: begin
          if (!we_q) rdata_q[gnt] <= rd_val;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  mem_region_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr   (addr_q),
    .region (region)
  );

  always_comb begin
    rd_val = '0;
    case (region)
      REG_RAM:  rd_val = ram_dout;
      REG_VRAM: rd_val = vram_dout;
      default:  rd_val = '0;
    endcase
  end

  // Strobes follow the registered state, so an async reset drops them at once.
  assign ram_ce    = (state == S_ACCESS) && (region == REG_RAM);
  assign ram_oce   = ram_ce && !we_q;
  assign ram_we    = ram_ce && we_q;
  assign vram_ce   = (state == S_ACCESS) && (region == REG_VRAM);
  assign vram_oce  = vram_ce && !we_q;
  assign vram_we   = vram_ce && we_q;
  assign mem_addr  = addr_q[RAM_AW-1:0];
  assign mem_wdata = wdata_q;

  logic [1:0]             rdy;
  logic [1:0]             err;
  logic [1:0][DATA_W-1:0] rdata_o;

  for (genvar m = 0; m < 2; m++) begin : g_master
    assign rdy[m]     = (state == S_RESP) && (gnt == 1'(m));
    assign err[m]     = rdy[m] && (region == REG_NONE);
    assign rdata_o[m] = (rdy[m] && !we_q) ? rd_val : rdata_q[m];
  end

  assign m0_ready = rdy[0];
  assign m1_ready = rdy[1];
  assign m0_err   = err[0];
  assign m1_err   = err[1];
  assign m0_rdata = rdata_o[0];
  assign m1_rdata = rdata_o[1];
endmodule
